rbt_s_ipv6_parser: RTL and testbench



---
 rtl/rbt_s_phv_pkg.sv | 47 ++++
 rtl/rbt_s_skid_buffer.sv | 82 ++++++++
 rtl/rbt_s_ipv6_parser.sv | 159 +++++++++++++++
 tb/tb_rbt_s_ipv6_parser.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbt_s_phv_pkg.sv
// Shared PHV layout constants for the reliable-send parse pipeline.
// Byte fields sit at the PHV LSB, then halves, then words.
package rbt_s_phv_pkg;

   // PHV byte indices
   localparam int unsigned PROTO_NO            = 0;
   localparam int unsigned HOP_LIMIT_NO        = 1;
   localparam int unsigned IP_OFFSET_NO        = 4;
   localparam int unsigned TRANSPORT_OFFSET_NO = 5;
   localparam int unsigned SEATL_OFFSET_NO     = 6;

   // PHV half/word indices
   localparam int unsigned PAYLOAD_LEN_NO      = 0;
   localparam int unsigned TAG_NO              = 0;
   localparam int unsigned SRC_ADDR_NO         = 1;
   localparam int unsigned DST_ADDR_NO         = 5;

   // Bit positions inside the tag word w0
   localparam int unsigned TAG_ETH             = 0;
   localparam int unsigned TAG_VLAN            = 1;
   localparam int unsigned TAG_IPV6            = 4;
   localparam int unsigned TAG_UDP             = 5;
   localparam int unsigned TAG_TCP             = 6;
   localparam int unsigned TAG_ICMPV6          = 7;
   localparam int unsigned TAG_IPV6_ERR        = 15;

   localparam int unsigned IPV6_HDR_BYTES      = 40;
   localparam int unsigned IPV6_HDR_BITS       = IPV6_HDR_BYTES * 8;
   localparam logic [3:0]  IPV6_VERSION        = 4'd6;

   localparam logic [7:0]  NH_UDP              = 8'h11;
   localparam logic [7:0]  NH_TCP              = 8'h06;
   localparam logic [7:0]  NH_ICMPV6           = 8'h3a;

   typedef enum logic [1:0] {
      SkEmpty,
      SkOne,
      SkFull
   } skid_state_e;

   typedef enum logic [1:0] {
      PathBypass,
      PathIpv6,
      PathErr
   } parse_path_e;

endpackage

// File: rtl/rbt_s_skid_buffer.sv
// Two-entry skid buffer with a registered ready; carries an opaque beat of WIDTH bits.
module rbt_s_skid_buffer
   import rbt_s_phv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   skid_state_e      state_q, state_d;
   logic [WIDTH-1:0] out_q, skid_q;
   logic             ready_q;
   logic             acc, drn;
   logic             load_out_in, load_out_skid, load_skid;

   assign acc       = in_valid & ready_q;
   assign drn       = out_valid & out_ready;
   assign out_valid = (state_q != SkEmpty);
   assign out_data  = out_q;
   assign in_ready  = ready_q;

   always_comb begin
      state_d       = state_q;
      load_out_in   = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      unique case (state_q)
         SkEmpty: begin
            if (acc) begin
               state_d     = SkOne;
               load_out_in = 1'b1;
            end
         end
         SkOne: begin
            if (acc && !drn) begin
               state_d   = SkFull;
               load_skid = 1'b1;
            end else if (drn && !acc) begin
               state_d = SkEmpty;
            end else if (acc && drn) begin
               load_out_in = 1'b1;
            end
         end
         SkFull: begin
            // ready_q is low here, so only the drain can happen
            if (drn) begin
               state_d       = SkOne;
               load_out_skid = 1'b1;
            end
         end
         default: state_d = SkEmpty;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SkEmpty;
         ready_q <= 1'b0;
         out_q   <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d != SkFull);
         if (load_out_in) begin
            out_q <= in_data;
         end else if (load_out_skid) begin
            out_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/rbt_s_ipv6_parser.sv
// IPv6 fixed-header parse stage: extracts fields into the PHV, strips 40 bytes,
// flags malformed IPv6 and bypasses everything else; output is skid-buffered.
module rbt_s_ipv6_parser
   import rbt_s_phv_pkg::*;
#(
   parameter int unsigned HEADER_WIDTH = 2048,
   parameter int unsigned PHV_WIDTH    = 408,
   parameter int unsigned PHV_B_NUM    = 7,
   parameter int unsigned PHV_H_NUM    = 2,
   parameter int unsigned PHV_W_NUM    = 10,
   parameter int unsigned CNT_WIDTH    = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_proto_hdr_valid,
   output logic                    in_proto_hdr_ready,
   input  logic [15:0]             in_proto_hdr_length,
   input  logic [HEADER_WIDTH-1:0] in_proto_hdr_data,
   input  logic [PHV_WIDTH-1:0]    in_proto_hdr_phv,
   output logic                    out_proto_hdr_valid,
   input  logic                    out_proto_hdr_ready,
   output logic [15:0]             out_proto_hdr_length,
   output logic [HEADER_WIDTH-1:0] out_proto_hdr_data,
   output logic [PHV_WIDTH-1:0]    out_proto_hdr_phv,
   output logic [CNT_WIDTH-1:0]    stat_ipv6_cnt,
   output logic [CNT_WIDTH-1:0]    stat_bypass_cnt,
   output logic [CNT_WIDTH-1:0]    stat_err_cnt
);

   localparam int unsigned T      = HEADER_WIDTH - 1;
   localparam int unsigned H_BASE = PHV_B_NUM * 8;
   localparam int unsigned W_BASE = H_BASE + PHV_H_NUM * 16;
   localparam int unsigned TAG_LSB = W_BASE + TAG_NO * 32;
   localparam int unsigned BEAT_W = 16 + HEADER_WIDTH + PHV_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic [3:0]              version;
   logic [15:0]             payload_len;
   logic [7:0]              next_hdr, hop_limit;
   logic [127:0]            src_addr, dst_addr;
   logic                    ipv6_tagged, hdr_ok;
   parse_path_e             path;
   logic [15:0]             par_len;
   logic [HEADER_WIDTH-1:0] par_data;
   logic [PHV_WIDTH-1:0]    par_phv;
   logic [BEAT_W-1:0]       skid_out;
   logic                    acc;

   assign version     = in_proto_hdr_data[T -: 4];
   assign payload_len = in_proto_hdr_data[T-32 -: 16];
   assign next_hdr    = in_proto_hdr_data[T-48 -: 8];
   assign hop_limit   = in_proto_hdr_data[T-56 -: 8];
   assign src_addr    = in_proto_hdr_data[T-64 -: 128];
   assign dst_addr    = in_proto_hdr_data[T-192 -: 128];

   assign ipv6_tagged = in_proto_hdr_phv[TAG_LSB + TAG_IPV6];
   assign hdr_ok      = (version == IPV6_VERSION) &&
                        (in_proto_hdr_length >= 16'(IPV6_HDR_BYTES));

   always_comb begin
      if (!ipv6_tagged) begin
         path = PathBypass;
      end else if (hdr_ok) begin
         path = PathIpv6;
      end else begin
         path = PathErr;
      end
   end

   always_comb begin
      par_len  = in_proto_hdr_length;
      par_data = in_proto_hdr_data;
      par_phv  = in_proto_hdr_phv;
      unique case (path)
         PathIpv6: begin
            // Addresses land MSB-word first: w1/w5 hold bits 127:96
            for (int i = 0; i < 4; i++) begin
               par_phv[W_BASE + (SRC_ADDR_NO + i) * 32 +: 32] = src_addr[127 - 32 * i -: 32];
               par_phv[W_BASE + (DST_ADDR_NO + i) * 32 +: 32] = dst_addr[127 - 32 * i -: 32];
            end
            par_phv[PROTO_NO * 8 +: 8]                = next_hdr;
            par_phv[HOP_LIMIT_NO * 8 +: 8]            = hop_limit;
            par_phv[H_BASE + PAYLOAD_LEN_NO * 16 +: 16] = payload_len;
            par_phv[TRANSPORT_OFFSET_NO * 8 +: 8] =
               in_proto_hdr_phv[IP_OFFSET_NO * 8 +: 8] + 8'(IPV6_HDR_BYTES);
            par_phv[SEATL_OFFSET_NO * 8 +: 8] =
               in_proto_hdr_phv[SEATL_OFFSET_NO * 8 +: 8] + 8'(IPV6_HDR_BYTES);
            case (next_hdr)
               NH_UDP:    par_phv[TAG_LSB + TAG_UDP]    = 1'b1;
               NH_TCP:    par_phv[TAG_LSB + TAG_TCP]    = 1'b1;
               NH_ICMPV6: par_phv[TAG_LSB + TAG_ICMPV6] = 1'b1;
               default:   ;
            endcase
            par_data = in_proto_hdr_data << IPV6_HDR_BITS;
            par_len  = in_proto_hdr_length - 16'(IPV6_HDR_BYTES);
         end
         PathErr: begin
            par_phv[TAG_LSB + TAG_IPV6_ERR] = 1'b1;
         end
         default: ;
      endcase
   end

   rbt_s_skid_buffer #(
      .WIDTH (BEAT_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_proto_hdr_valid),
      .in_ready  (in_proto_hdr_ready),
      .in_data   ({par_len, par_data, par_phv}),
      .out_valid (out_proto_hdr_valid),
      .out_ready (out_proto_hdr_ready),
      .out_data  (skid_out)
   );

   assign {out_proto_hdr_length, out_proto_hdr_data, out_proto_hdr_phv} = skid_out;

   // Statistics
   logic [CNT_WIDTH-1:0] ipv6_cnt_q, ipv6_cnt_d;
   logic [CNT_WIDTH-1:0] bypass_cnt_q, bypass_cnt_d;
   logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == '1) ? v : v + CNT_ONE;
   endfunction

   assign acc = in_proto_hdr_valid & in_proto_hdr_ready;

   always_comb begin
      ipv6_cnt_d   = ipv6_cnt_q;
      bypass_cnt_d = bypass_cnt_q;
      err_cnt_d    = err_cnt_q;
      if (acc) begin
         case (path)
            PathIpv6: ipv6_cnt_d   = sat_inc(ipv6_cnt_q);
            PathErr:  err_cnt_d    = sat_inc(err_cnt_q);
            default:  bypass_cnt_d = sat_inc(bypass_cnt_q);
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ipv6_cnt_q   <= '0;
         bypass_cnt_q <= '0;
         err_cnt_q    <= '0;
      end else begin
         ipv6_cnt_q   <= ipv6_cnt_d;
         bypass_cnt_q <= bypass_cnt_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign stat_ipv6_cnt   = ipv6_cnt_q;
   assign stat_bypass_cnt = bypass_cnt_q;
   assign stat_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_rbt_s_ipv6_parser.sv
// Self-checking bench for rbt_s_ipv6_parser: directed cases, backpressure, random
// traffic against a byte-level reference model, counter saturation and mid-run reset.
module tb_rbt_s_ipv6_parser;

   localparam int HW = 2048;
   localparam int PW = 408;
   localparam int HB = 56;   // first half-word bit
   localparam int WB = 88;   // first word bit
   localparam int NB = HW / 8;

   typedef struct packed {
      logic [15:0]   len;
      logic [HW-1:0] data;
      logic [PW-1:0] phv;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [15:0]   in_len = '0;
   logic [HW-1:0] in_data = '0;
   logic [PW-1:0] in_phv = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [15:0]   out_len;
   logic [HW-1:0] out_data;
   logic [PW-1:0] out_phv;
   logic [31:0]   stat_ipv6, stat_byp, stat_err;
   logic          s_in_ready, s_out_valid;
   logic [15:0]   s_out_len;
   logic [HW-1:0] s_out_data;
   logic [PW-1:0] s_out_phv;
   logic [3:0]    s_stat_ipv6, s_stat_byp, s_stat_err;

   always #5 clk = ~clk;

   rbt_s_ipv6_parser dut (
      .clk(clk), .rst_n(rst_n),
      .in_proto_hdr_valid(in_valid), .in_proto_hdr_ready(in_ready),
      .in_proto_hdr_length(in_len), .in_proto_hdr_data(in_data), .in_proto_hdr_phv(in_phv),
      .out_proto_hdr_valid(out_valid), .out_proto_hdr_ready(out_ready),
      .out_proto_hdr_length(out_len), .out_proto_hdr_data(out_data),
      .out_proto_hdr_phv(out_phv),
      .stat_ipv6_cnt(stat_ipv6), .stat_bypass_cnt(stat_byp), .stat_err_cnt(stat_err)
   );

   rbt_s_ipv6_parser #(.CNT_WIDTH(4)) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .in_proto_hdr_valid(in_valid), .in_proto_hdr_ready(s_in_ready),
      .in_proto_hdr_length(in_len), .in_proto_hdr_data(in_data), .in_proto_hdr_phv(in_phv),
      .out_proto_hdr_valid(s_out_valid), .out_proto_hdr_ready(out_ready),
      .out_proto_hdr_length(s_out_len), .out_proto_hdr_data(s_out_data),
      .out_proto_hdr_phv(s_out_phv),
      .stat_ipv6_cnt(s_stat_ipv6), .stat_bypass_cnt(s_stat_byp), .stat_err_cnt(s_stat_err)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_beat(input string tag, input beat_t o, input beat_t e);
      chk({tag, "_len"}, 512'(o.len), 512'(e.len));
      chk({tag, "_phv"}, 512'(o.phv), 512'(e.phv));
      for (int k = 0; k < HW / 512; k++)
         chk($sformatf("%s_data%0d", tag, k), o.data[512*k +: 512], e.data[512*k +: 512]);
   endtask

   // Reference model: header viewed as a byte array (byte 0 = MSB), PHV as field arrays
   function automatic int path_of(input beat_t b);
      logic [3:0] ver;
      ver = b.data[HW-1 -: 4];
      if (!b.phv[WB + 4]) return 0;
      if (ver == 4'd6 && b.len >= 16'd40) return 1;
      return 2;
   endfunction

   function automatic beat_t model(input beat_t b);
      logic [7:0]  hb [NB];
      logic [7:0]  pb [7];
      logic [15:0] ph [2];
      logic [31:0] pw [10];
      beat_t r;
      int p;
      r = b;
      p = path_of(b);
      for (int i = 0; i < NB; i++) hb[i] = b.data[HW-1-8*i -: 8];
      for (int i = 0; i < 7; i++)  pb[i] = b.phv[8*i +: 8];
      for (int i = 0; i < 2; i++)  ph[i] = b.phv[HB+16*i +: 16];
      for (int i = 0; i < 10; i++) pw[i] = b.phv[WB+32*i +: 32];
      if (p == 0) return r;
      if (p == 2) begin
         r.phv[WB + 15] = 1'b1;
         return r;
      end
      for (int k = 0; k < 4; k++) begin
         pw[1+k] = {hb[8+4*k], hb[9+4*k], hb[10+4*k], hb[11+4*k]};
         pw[5+k] = {hb[24+4*k], hb[25+4*k], hb[26+4*k], hb[27+4*k]};
      end
      pb[0] = hb[6];
      pb[1] = hb[7];
      ph[0] = {hb[4], hb[5]};
      pb[5] = pb[4] + 8'd40;
      pb[6] = pb[6] + 8'd40;
      if (hb[6] == 8'h11) pw[0][5] = 1'b1;
      if (hb[6] == 8'h06) pw[0][6] = 1'b1;
      if (hb[6] == 8'h3a) pw[0][7] = 1'b1;
      for (int i = 0; i < NB; i++) hb[i] = (i + 40 < NB) ? hb[i+40] : 8'h00;
      for (int i = 0; i < NB; i++) r.data[HW-1-8*i -: 8] = hb[i];
      for (int i = 0; i < 7; i++)  r.phv[8*i +: 8] = pb[i];
      for (int i = 0; i < 2; i++)  r.phv[HB+16*i +: 16] = ph[i];
      for (int i = 0; i < 10; i++) r.phv[WB+32*i +: 32] = pw[i];
      r.len = b.len - 16'd40;
      return r;
   endfunction

   function automatic beat_t mk(input logic [15:0] len, input logic [31:0] w0,
                                input logic [3:0] ver, input logic [7:0] nh);
      beat_t b;
      for (int i = 0; i < HW / 32; i++) b.data[32*i +: 32] = $urandom;
      for (int i = 0; i < PW / 8; i++)  b.phv[8*i +: 8] = 8'($urandom);
      b.len = len;
      b.phv[WB +: 32] = w0;
      b.data[HW-1 -: 4] = ver;
      b.data[HW-1-48 -: 8] = nh;
      return b;
   endfunction

   function automatic beat_t rand_beat();
      logic [7:0] nhs [5];
      int kind, v;
      beat_t b;
      nhs[0] = 8'h11; nhs[1] = 8'h06; nhs[2] = 8'h3a; nhs[3] = 8'h2b; nhs[4] = 8'($urandom);
      kind = $urandom_range(0, 3);
      v = $urandom_range(0, 14);
      if (v >= 6) v++;
      b = mk(16'($urandom_range(0, 256)), $urandom, 4'($urandom), nhs[$urandom_range(0, 4)]);
      case (kind)
         0: b.phv[WB+4] = 1'b0;
         1: begin
            b.phv[WB+4] = 1'b1;
            b.data[HW-1 -: 4] = 4'd6;
            b.len = 16'($urandom_range(40, 256));
         end
         2: begin
            b.phv[WB+4] = 1'b1;
            b.data[HW-1 -: 4] = 4'(v);
         end
         default: begin
            b.phv[WB+4] = 1'b1;
            b.data[HW-1 -: 4] = 4'd6;
            b.len = 16'($urandom_range(0, 39));
         end
      endcase
      return b;
   endfunction

   // Scoreboard and counter model, sampled mid-cycle
   beat_t exp_q[$];
   int    n_ipv6 = 0, n_err = 0, n_byp = 0;
   beat_t in_b, out_b;
   assign in_b  = '{len: in_len, data: in_data, phv: in_phv};
   assign out_b = '{len: out_len, data: out_data, phv: out_phv};

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         n_ipv6 = 0; n_err = 0; n_byp = 0;
      end else begin
         if (out_valid && out_ready) begin
            chk("sb_expected_beat", 512'(exp_q.size() != 0), 512'(1));
            if (exp_q.size() != 0) chk_beat("sb", out_b, exp_q.pop_front());
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_b));
            case (path_of(in_b))
               0: n_byp++;
               1: n_ipv6++;
               default: n_err++;
            endcase
         end
      end
   end

   task automatic drive(input beat_t b);
      in_len = b.len; in_data = b.data; in_phv = b.phv;
   endtask

   task automatic send(input beat_t b);
      int t;
      t = 0;
      @(posedge clk); #1;
      drive(b);
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         t++;
      end while (!in_ready && t < 50);
      chk("send_accept", 512'(in_ready), 512'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int sat15(input int n);
      return (n > 15) ? 15 : n;
   endfunction

   task automatic check_counters(input string tag);
      chk({tag, "_ipv6"}, 512'(stat_ipv6), 512'(n_ipv6));
      chk({tag, "_err"}, 512'(stat_err), 512'(n_err));
      chk({tag, "_byp"}, 512'(stat_byp), 512'(n_byp));
      chk({tag, "_sat_ipv6"}, 512'(s_stat_ipv6), 512'(sat15(n_ipv6)));
      chk({tag, "_sat_err"}, 512'(s_stat_err), 512'(sat15(n_err)));
      chk({tag, "_sat_byp"}, 512'(s_stat_byp), 512'(sat15(n_byp)));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      beat_t b, a_b, b_b, c_b, cur;
      int    sent, cyc;
      logic [7:0] byte40;

      // Reset state
      #2 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", 512'(in_ready), 512'(0));
      chk("rst_out_valid", 512'(out_valid), 512'(0));
      chk_beat("rst_out", out_b, '0);
      chk("rst_ipv6", 512'(stat_ipv6), 512'(0));
      chk("rst_err", 512'(stat_err), 512'(0));
      chk("rst_byp", 512'(stat_byp), 512'(0));
      repeat (3) @(posedge clk);
      @(negedge clk); #1 rst_n = 1'b1;
      chk("rst_ready_before_edge", 512'(in_ready), 512'(0));
      @(posedge clk); #1;
      chk("rst_ready_after_edge", 512'(in_ready), 512'(1));

      // IPv6/UDP
      b = mk(16'd120, 32'h11, 4'd6, 8'h11);
      b.data[HW-1-64 -: 128] = 128'h2001_0db8_0000_0000_0000_0000_0000_0001;
      b.phv[4*8 +: 8] = 8'd14;
      b.phv[6*8 +: 8] = 8'd14;
      byte40 = b.data[HW-1-320 -: 8];
      chk("udp_idle_valid", 512'(out_valid), 512'(0));
      send(b);
      chk("udp_valid", 512'(out_valid), 512'(1));
      chk("udp_len", 512'(out_len), 512'(80));
      chk("udp_w0", 512'(out_phv[WB +: 32]), 512'(32'h31));
      chk("udp_w1", 512'(out_phv[WB+32 +: 32]), 512'(32'h2001_0db8));
      chk("udp_w4", 512'(out_phv[WB+128 +: 32]), 512'(32'h1));
      chk("udp_b0", 512'(out_phv[0 +: 8]), 512'(8'h11));
      chk("udp_b5", 512'(out_phv[40 +: 8]), 512'(54));
      chk("udp_b6", 512'(out_phv[48 +: 8]), 512'(54));
      chk("udp_byte0", 512'(out_data[HW-1 -: 8]), 512'(byte40));
      idle(2);
      chk("udp_cnt", 512'(stat_ipv6), 512'(1));

      // Version 4 and short IPv6 are errors
      b = mk(16'd60, 32'h10, 4'd4, 8'h06);
      send(b);
      chk("v4_w0", 512'(out_phv[WB +: 32]), 512'(32'h8010));
      chk("v4_len", 512'(out_len), 512'(60));
      chk("v4_data_hi", out_data[HW-1 -: 512], b.data[HW-1 -: 512]);
      idle(2);
      chk("v4_err_cnt", 512'(stat_err), 512'(1));
      b = mk(16'd39, 32'h10, 4'd6, 8'h11);
      send(b);
      chk("short_err_bit", 512'(out_phv[WB + 15]), 512'(1));
      chk("short_len", 512'(out_len), 512'(39));

      // Bypass
      b = mk(16'd77, 32'h1, 4'd6, 8'h11);
      send(b);
      chk_beat("byp", out_b, b);
      idle(2);
      chk("byp_cnt", 512'(stat_byp), 512'(1));
      check_counters("directed");

      // Backpressure: A held, B in skid, C waits for release
      a_b = mk(16'd100, 32'h1, 4'd6, 8'h0);
      b_b = mk(16'd101, 32'h1, 4'd6, 8'h0);
      c_b = mk(16'd102, 32'h1, 4'd6, 8'h0);
      out_ready = 1'b0;
      drive(a_b); in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_ready_one", 512'(in_ready), 512'(1));
      drive(b_b);
      @(posedge clk); #1;
      drive(c_b);
      for (int i = 0; i < 2; i++) begin
         chk("bp_ready_full", 512'(in_ready), 512'(0));
         chk("bp_hold_valid", 512'(out_valid), 512'(1));
         chk_beat("bp_hold_a", out_b, a_b);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_second_b", 512'(out_len), 512'(101));
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_third_c", 512'(out_len), 512'(102));
      idle(2);
      check_counters("bp");

      // Random traffic, 50% valid / 50% ready
      sent = 0;
      cyc = 0;
      cur = rand_beat();
      while (sent < 1000 && cyc < 20000) begin
         @(posedge clk); #1;
         drive(cur);
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (in_valid && in_ready) begin
            sent++;
            cur = rand_beat();
         end
         cyc++;
      end
      chk("rand_sent", 512'(sent), 512'(1000));
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("rand_drain", 512'(exp_q.size()), 512'(0));
      idle(2);
      check_counters("rand");
      chk("rand_cnt_sum", 512'(stat_ipv6 + stat_err + stat_byp), 512'(1007));

      // Reset while full
      out_ready = 1'b0;
      drive(a_b); in_valid = 1'b1;
      @(posedge clk); #1;
      drive(b_b);
      @(posedge clk); #1;
      chk("rf_full_ready", 512'(in_ready), 512'(0));
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rf_out_valid", 512'(out_valid), 512'(0));
      chk("rf_in_ready", 512'(in_ready), 512'(0));
      chk("rf_ipv6", 512'(stat_ipv6), 512'(0));
      chk("rf_byp", 512'(stat_byp), 512'(0));
      chk("rf_sat_byp", 512'(s_stat_byp), 512'(0));
      @(negedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rf_ready_next_edge", 512'(in_ready), 512'(1));
      chk("rf_valid_after", 512'(out_valid), 512'(0));

      // 20 IPv6 beats saturate the 4-bit counter
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         b = mk(16'(40 + i), 32'h10, 4'd6, 8'h06);
         send(b);
      end
      idle(3);
      chk("sat_wide", 512'(stat_ipv6), 512'(20));
      chk("sat_narrow", 512'(s_stat_ipv6), 512'(15));
      check_counters("sat");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
